// File: rtl/edp_pkg.sv
// Shared encodings for the EBOX multiply/divide unit: operation codes and controller states.
package edp_pkg;

  typedef enum logic [1:0] {
    OpMulu = 2'b00,
    OpMuls = 2'b01,
    OpDivu = 2'b10,
    OpDivs = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFixup,
    StDone
  } state_e;

endpackage

// File: rtl/edp_muldiv_if.sv
// Request/result bundle between a requester (master) and the multiply/divide unit (slave).
interface edp_muldiv_if #(
  parameter int unsigned WIDTH = 36
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opALo;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;
  logic             noDivide;

  modport master (
    output start, op, opA, opALo, opB,
    input  busy, done, resHi, resLo, noDivide
  );

  modport slave (
    input  start, op, opA, opALo, opB,
    output busy, done, resHi, resLo, noDivide
  );
endinterface

// File: rtl/edp_addsub.sv
// Width-bit adder/subtractor; with sub=1 cout=1 means a >= b (no borrow).
module edp_addsub #(
  parameter int unsigned Width = 37
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             sub,
  output logic [Width-1:0] sum,
  output logic             cout
);

  logic [Width-1:0] b_x;

  assign b_x         = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{Width{1'b0}}, sub};

endmodule

// File: rtl/edp_muldiv.sv
// Iterative radix-2 multiply (shift-add) and restoring divide over sign magnitudes,
// with results registered one cycle after the DONE state.
module edp_muldiv
  import edp_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned CNT_W = 6
) (
  input logic         eboxClk,
  input logic         eboxReset,
  edp_muldiv_if.slave bus
);

  localparam int unsigned W = WIDTH;
  localparam logic [W-1:0] QMaxPos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMaxNeg = {1'b1, {(W-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q;
  logic [W-1:0]     a_q, alo_q, b_q, bm_q, ar_q, mq_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ndiv_q;
  logic             done_q, nodiv_out_q;
  logic [W-1:0]     res_hi_q, res_lo_q;

  logic             is_signed, is_div, sign_a, sign_b, q_neg, prep_ndiv, fix_ovf;
  logic [W-1:0]     a_mag, b_mag;
  logic [2*W-1:0]   dvd_mag, prod_neg;
  logic [W:0]       as_a, as_b, as_sum;
  logic             as_cout;

  always_comb begin
    is_div    = (op_q == OpDivu) || (op_q == OpDivs);
    is_signed = (op_q == OpMuls) || (op_q == OpDivs);
    sign_a    = is_signed & a_q[W-1];
    sign_b    = is_signed & b_q[W-1];
    q_neg     = sign_a ^ sign_b;
    a_mag     = sign_a ? -a_q : a_q;
    b_mag     = sign_b ? -b_q : b_q;
    dvd_mag   = sign_a ? -{a_q, alo_q} : {a_q, alo_q};
    prod_neg  = -{ar_q, mq_q};
    // Quotient fits in W bits only while the dividend high word is below the divisor.
    prep_ndiv = (b_q == '0) || (dvd_mag[2*W-1:W] >= b_mag);
    fix_ovf   = is_div & is_signed & (mq_q > (q_neg ? QMaxNeg : QMaxPos));
    if (is_div) begin
      as_a = {ar_q, mq_q[W-1]};
      as_b = {1'b0, bm_q};
    end else begin
      as_a = {1'b0, ar_q};
      as_b = mq_q[0] ? {1'b0, bm_q} : '0;
    end
  end

  edp_addsub #(
    .Width (W + 1)
  ) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (is_div),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StPrep;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StPrep:  state_d = (is_div && prep_ndiv) ? StDone : StIter;
      StIter:  state_d = (cnt_q == '0) ? StFixup : StIter;
      StFixup: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      op_q        <= OpMulu;
      a_q         <= '0;
      alo_q       <= '0;
      b_q         <= '0;
      bm_q        <= '0;
      ar_q        <= '0;
      mq_q        <= '0;
      cnt_q       <= '0;
      ndiv_q      <= 1'b0;
      done_q      <= 1'b0;
      nodiv_out_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            op_q   <= op_e'(bus.op);
            a_q    <= bus.opA;
            alo_q  <= bus.opALo;
            b_q    <= bus.opB;
            ndiv_q <= 1'b0;
          end
        end
        StPrep: begin
          cnt_q <= CNT_W'(W - 1);
          if (is_div) begin
            ar_q   <= dvd_mag[2*W-1:W];
            mq_q   <= dvd_mag[W-1:0];
            bm_q   <= b_mag;
            ndiv_q <= prep_ndiv;
          end else begin
            ar_q <= '0;
            mq_q <= b_mag;
            bm_q <= a_mag;
          end
        end
        StIter: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
          if (is_div) begin
            // Restore by simply keeping the shifted partial remainder when the trial borrows.
            ar_q <= as_cout ? as_sum[W-1:0] : as_a[W-1:0];
            mq_q <= {mq_q[W-2:0], as_cout};
          end else begin
            ar_q <= as_sum[W:1];
            mq_q <= {as_sum[0], mq_q[W-1:1]};
          end
        end
        StFixup: begin
          if (is_div) begin
            if (fix_ovf) begin
              ndiv_q <= 1'b1;
            end else begin
              if (q_neg) mq_q <= -mq_q;
              if (sign_a) ar_q <= -ar_q;
            end
          end else if (q_neg) begin
            {ar_q, mq_q} <= prod_neg;
          end
        end
        default: ;
      endcase
      if (state_q == StDone) begin
        done_q      <= 1'b1;
        nodiv_out_q <= ndiv_q;
        res_hi_q    <= ndiv_q ? a_q : ar_q;
        res_lo_q    <= ndiv_q ? alo_q : mq_q;
      end
    end
  end

  assign bus.busy     = (state_q == StPrep) || (state_q == StIter) || (state_q == StFixup);
  assign bus.done     = done_q;
  assign bus.resHi    = res_hi_q;
  assign bus.resLo    = res_lo_q;
  assign bus.noDivide = nodiv_out_q;

endmodule

// File: doc/edp_muldiv.md
EDP_MULDIV -- requirements
Module: edp_muldiv

Interface
REQ-001 Parameter WIDTH, default 36, SHALL set the word width W; legal values are even and between 8 and 64 inclusive.
REQ-002 Parameter CNT_W, default 6, SHALL set the iteration counter width and SHALL satisfy 2**CNT_W > W.
REQ-003 eboxClk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 eboxReset  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  in  1  SHALL request an operation; sampled only while busy=0.
REQ-006 op  in  2  SHALL select the operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
REQ-007 opA  in  W  SHALL be the multiplicand (MUL) or the dividend high word (DIV).
REQ-008 opALo  in  W  SHALL be the dividend low word (DIV); it is ignored for MUL.
REQ-009 opB  in  W  SHALL be the multiplier (MUL) or the divisor (DIV).
REQ-010 busy  out  1  SHALL be high while an operation is in progress.
REQ-011 done  out  1  SHALL be a one-cycle pulse marking results valid.
REQ-012 resHi  out  W  SHALL carry the product high word (MUL) or the remainder (DIV), AR-equivalent.
REQ-013 resLo  out  W  SHALL carry the product low word (MUL) or the quotient (DIV), MQ-equivalent.
REQ-014 noDivide  out  1  SHALL flag a DIV overflow; it is valid with done.

Function
REQ-015 FSM states SHALL be IDLE, PREP, ITER, FIXUP and DONE; busy=1 in PREP, ITER and FIXUP.
REQ-016 IDLE or DONE with start=1 SHALL latch op and operands, and go to PREP.
REQ-017 PREP SHALL convert operands to magnitudes for MULS/DIVS, load counter=W-1 and go to ITER; for DIV, noDivide conditions (REQ-020) SHALL go to DONE instead.
REQ-018 Each ITER cycle SHALL perform one radix-2 step:
  - MUL: shift-add, with the multiplier in the MQ-equivalent register shifting right.
  - DIV: restoring shift-subtract, with the quotient bit entering at the LSB.
  - The counter SHALL decrement each step; ITER lasts exactly W cycles, then goes to FIXUP.
REQ-019 FIXUP SHALL apply signs:
  - MULS product is the 2W-bit two's complement.
  - DIVS quotient sign is sign(opA) XOR sign(opB); remainder sign is sign(opA).
  - FIXUP then goes to DONE.
REQ-020 noDivide=1 SHALL be set when any of these holds:
  - opB=0;
  - the magnitude of opA is greater than or equal to the magnitude of opB, unsigned (detected in PREP);
  - DIVS only: the quotient magnitude exceeds 2**(W-1)-1 for a positive quotient or 2**(W-1) for a negative one (detected in FIXUP).
REQ-021 On noDivide=1, resHi/resLo SHALL equal the original opA/opALo.
REQ-022 DONE SHALL assert done for one cycle, then go to IDLE unless start=1 (REQ-016).
REQ-023 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+W+3; a PREP-detected noDivide SHALL give done after edge k+2.
REQ-024 resHi, resLo and noDivide SHALL hold their values from done until the next accepted start.
REQ-025 start while busy=1 SHALL be ignored, with no queueing.
REQ-026 All arithmetic SHALL be modulo 2**(2W); the most negative MULS operands SHALL yield the exact 2W-bit product.

Reset
REQ-027 eboxReset=1 SHALL force state IDLE, and busy=0, done=0, noDivide=0, resHi=0, resLo=0, counter=0, in any state.
REQ-028 eboxReset=1 SHALL take priority over start in the same cycle.
REQ-029 An operation interrupted by reset SHALL produce no done pulse.

Structure
REQ-030 Package edp_pkg SHALL hold the op encodings (MULU, MULS, DIVU, DIVS) and the FSM state enumeration.
REQ-031 A W+1-bit adder/subtractor SHALL be the single sub-module edp_addsub (inputs a, b, sub; outputs sum, cout), instantiated once and shared by MUL and DIV.

Verification
REQ-032 With W=36, MULU, opA=0o777777777777, opB=2: resHi=1, resLo=0o777777777776, done after exactly 39 cycles.
REQ-033 MULS with opA=-3, opB=5: resHi=all ones, resLo=-15 (36-bit two's complement).
REQ-034 DIVS with opA:opALo=-7 (72-bit), opB=2: resLo=-3, resHi=-1, noDivide=0.
REQ-035 DIVU with opB=0, opA=5, opALo=9: noDivide=1, resHi=5, resLo=9, done 2 cycles after start.
REQ-036 eboxReset asserted in ITER cycle 10 of a MULU: all outputs 0 next cycle, no done; a fresh start then completes normally.
REQ-037 start held high continuously: back-to-back operations, start re-accepted in the DONE cycle, and start during busy ignored (results match the first operands only).
